// File: rtl/dispatch_stage.sv
// dispatch_stage: single-bundle hold register between rename and ROB/issue queue.
// A renamed bundle is captured into the hold register and dispatched
// all-or-nothing once the ROB and issue queue both have room for every valid
// lane. Allocates ROB indices from a wrapping tail pointer and tracks
// per-physical-register busy bits to report source readiness.
//
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   ren_*                           renamed bundle from rename (FETCH_W lanes)
//   dispatch_ready                  bundle accepted from rename this cycle
//   rob_free_count, iq_free_count   free entries downstream
//   wb_valid, wb_prd                writeback completions (clear busy bits)
//   flush_pipeline                  squash hold register, tail and busy table
//   disp_en                         per-lane write strobe to ROB / issue queue
//   disp_rob_idx                    allocated ROB index per lane
//   disp_prs1_rdy, disp_prs2_rdy    source operand readiness per lane
//   disp_prd/prs1/prs2/pc/imm/is_load/is_store  held bundle fields
//
// Build option: define DISPATCH_WB_BYPASS_EN to let a same-cycle writeback
// mark a matching held source as ready.
module dispatch_stage #(
  parameter int unsigned FETCH_W   = 2,
  parameter int unsigned PHYS_REGS = 48,
  parameter int unsigned ROB_DEPTH = 32
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [FETCH_W-1:0]                        ren_valid,
  input  logic [FETCH_W-1:0]                        ren_rd_valid,
  input  logic [FETCH_W-1:0]                        ren_rs1_valid,
  input  logic [FETCH_W-1:0]                        ren_rs2_valid,
  input  logic [FETCH_W-1:0]                        ren_is_load,
  input  logic [FETCH_W-1:0]                        ren_is_store,
  input  logic [FETCH_W-1:0][5:0]                   ren_prd,
  input  logic [FETCH_W-1:0][5:0]                   ren_prs1,
  input  logic [FETCH_W-1:0][5:0]                   ren_prs2,
  input  logic [FETCH_W-1:0][31:0]                  ren_pc,
  input  logic [FETCH_W-1:0][31:0]                  ren_imm,
  output logic                                      dispatch_ready,
  input  logic [5:0]                                rob_free_count,
  input  logic [5:0]                                iq_free_count,
  input  logic [1:0]                                wb_valid,
  input  logic [1:0][5:0]                           wb_prd,
  input  logic                                      flush_pipeline,
  output logic [FETCH_W-1:0]                        disp_en,
  output logic [FETCH_W-1:0][$clog2(ROB_DEPTH)-1:0] disp_rob_idx,
  output logic [FETCH_W-1:0]                        disp_prs1_rdy,
  output logic [FETCH_W-1:0]                        disp_prs2_rdy,
  output logic [FETCH_W-1:0][5:0]                   disp_prd,
  output logic [FETCH_W-1:0][5:0]                   disp_prs1,
  output logic [FETCH_W-1:0][5:0]                   disp_prs2,
  output logic [FETCH_W-1:0][31:0]                  disp_pc,
  output logic [FETCH_W-1:0][31:0]                  disp_imm,
  output logic [FETCH_W-1:0]                        disp_is_load,
  output logic [FETCH_W-1:0]                        disp_is_store
);

  localparam int unsigned PREG_W = 6;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned IDX_W  = $clog2(ROB_DEPTH);

  logic                              r_hold_valid;
  logic [FETCH_W-1:0]                r_valid, r_rd_valid, r_rs1_valid, r_rs2_valid;
  logic [FETCH_W-1:0]                r_is_load, r_is_store;
  logic [FETCH_W-1:0][PREG_W-1:0]    r_prd, r_prs1, r_prs2;
  logic [FETCH_W-1:0][31:0]          r_pc, r_imm;
  logic [IDX_W-1:0]                  r_tail;
  logic [PHYS_REGS-1:0]              r_busy;

  logic [FETCH_W-1:0]                w_lane;
  logic [CNT_W-1:0]                  w_need;
  logic                              w_fire;
  logic                              w_capture;
  logic [IDX_W-1:0]                  w_off;
  logic [PHYS_REGS-1:0]              w_busy_nxt;
  logic [FETCH_W-1:0]                w_byp1, w_byp2;

  // Source readiness: unused sources are ready; otherwise not busy (or bypassed),
  // unless an older lane of the same bundle writes that preg.
  function automatic logic src_rdy(
    input logic                           used,
    input logic [PREG_W-1:0]              p,
    input logic                           byp,
    input int unsigned                    lane,
    input logic [PHYS_REGS-1:0]           busy,
    input logic [FETCH_W-1:0]             lane_v,
    input logic [FETCH_W-1:0]             rdv,
    input logic [FETCH_W-1:0][PREG_W-1:0] prd
  );
    logic rdy;
    rdy = 1'b1;
    if (used) begin
      if (32'(p) < PHYS_REGS) rdy = ~busy[p];
      if (byp) rdy = 1'b1;
      for (int unsigned j = 0; j < lane; j++) begin
        if (lane_v[j] && rdv[j] && (prd[j] != '0) && (prd[j] == p)) rdy = 1'b0;
      end
    end
    return rdy;
  endfunction

  // Occupancy, fire condition and handshake with rename.
  always_comb begin
    w_lane = r_valid & {FETCH_W{r_hold_valid}};
    w_need = '0;
    for (int i = 0; i < FETCH_W; i++) w_need = w_need + CNT_W'(w_lane[i]);
    w_fire = r_hold_valid && (w_need <= rob_free_count) &&
             (w_need <= iq_free_count) && !flush_pipeline;
    dispatch_ready = (!r_hold_valid || w_fire) && !flush_pipeline;
    w_capture      = (|ren_valid) && dispatch_ready;
    disp_en        = w_fire ? w_lane : '0;
  end

  // ROB index per lane: tail plus number of older valid lanes.
  always_comb begin
    w_off        = '0;
    disp_rob_idx = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      disp_rob_idx[i] = r_tail + w_off;
      w_off           = w_off + IDX_W'(w_lane[i]);
    end
  end

`ifdef DISPATCH_WB_BYPASS_EN
  // Same-cycle writeback match on held sources.
  always_comb begin
    w_byp1 = '0;
    w_byp2 = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (wb_valid[k] && (wb_prd[k] == r_prs1[i])) w_byp1[i] = 1'b1;
        if (wb_valid[k] && (wb_prd[k] == r_prs2[i])) w_byp2[i] = 1'b1;
      end
    end
  end
`else
  assign w_byp1 = '0;
  assign w_byp2 = '0;
`endif

  always_comb begin
    disp_prs1_rdy = '1;
    disp_prs2_rdy = '1;
    for (int i = 0; i < FETCH_W; i++) begin
      disp_prs1_rdy[i] = src_rdy(r_rs1_valid[i], r_prs1[i], w_byp1[i], i,
                                 r_busy, r_valid, r_rd_valid, r_prd);
      disp_prs2_rdy[i] = src_rdy(r_rs2_valid[i], r_prs2[i], w_byp2[i], i,
                                 r_busy, r_valid, r_rd_valid, r_prd);
    end
  end

  // Busy table update: writeback clears first, dispatch sets override.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int k = 0; k < 2; k++) begin
      if (wb_valid[k] && (32'(wb_prd[k]) < PHYS_REGS)) w_busy_nxt[wb_prd[k]] = 1'b0;
    end
    if (w_fire) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (w_lane[i] && r_rd_valid[i] && (r_prd[i] != '0) && (32'(r_prd[i]) < PHYS_REGS))
          w_busy_nxt[r_prd[i]] = 1'b1;
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_valid <= 1'b0;
      r_valid      <= '0;
      r_rd_valid   <= '0;
      r_rs1_valid  <= '0;
      r_rs2_valid  <= '0;
      r_is_load    <= '0;
      r_is_store   <= '0;
      r_prd        <= '0;
      r_prs1       <= '0;
      r_prs2       <= '0;
      r_pc         <= '0;
      r_imm        <= '0;
      r_tail       <= '0;
      r_busy       <= '0;
    end else if (flush_pipeline) begin
      r_hold_valid <= 1'b0;
      r_tail       <= '0;
      r_busy       <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_fire) r_tail <= r_tail + IDX_W'(w_need);
      if (w_capture) begin
        r_hold_valid <= 1'b1;
        r_valid      <= ren_valid;
        r_rd_valid   <= ren_rd_valid;
        r_rs1_valid  <= ren_rs1_valid;
        r_rs2_valid  <= ren_rs2_valid;
        r_is_load    <= ren_is_load;
        r_is_store   <= ren_is_store;
        r_prd        <= ren_prd;
        r_prs1       <= ren_prs1;
        r_prs2       <= ren_prs2;
        r_pc         <= ren_pc;
        r_imm        <= ren_imm;
      end else if (w_fire) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  assign disp_prd      = r_prd;
  assign disp_prs1     = r_prs1;
  assign disp_prs2     = r_prs2;
  assign disp_pc       = r_pc;
  assign disp_imm      = r_imm;
  assign disp_is_load  = r_is_load;
  assign disp_is_store = r_is_store;

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed self-checking bench for dispatch_stage.
module tb_dispatch_stage;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       ren_valid, ren_rd_valid, ren_rs1_valid, ren_rs2_valid;
  logic [1:0]       ren_is_load, ren_is_store;
  logic [1:0][5:0]  ren_prd, ren_prs1, ren_prs2;
  logic [1:0][31:0] ren_pc, ren_imm;
  logic             dispatch_ready;
  logic [5:0]       rob_free_count, iq_free_count;
  logic [1:0]       wb_valid;
  logic [1:0][5:0]  wb_prd;
  logic             flush_pipeline;
  logic [1:0]       disp_en;
  logic [1:0][4:0]  disp_rob_idx;
  logic [1:0]       disp_prs1_rdy, disp_prs2_rdy;
  logic [1:0][5:0]  disp_prd, disp_prs1, disp_prs2;
  logic [1:0][31:0] disp_pc, disp_imm;
  logic [1:0]       disp_is_load, disp_is_store;

  int total = 0;
  int bad   = 0;

  dispatch_stage dut (
    .clk(clk), .reset_n(reset_n),
    .ren_valid(ren_valid), .ren_rd_valid(ren_rd_valid),
    .ren_rs1_valid(ren_rs1_valid), .ren_rs2_valid(ren_rs2_valid),
    .ren_is_load(ren_is_load), .ren_is_store(ren_is_store),
    .ren_prd(ren_prd), .ren_prs1(ren_prs1), .ren_prs2(ren_prs2),
    .ren_pc(ren_pc), .ren_imm(ren_imm),
    .dispatch_ready(dispatch_ready),
    .rob_free_count(rob_free_count), .iq_free_count(iq_free_count),
    .wb_valid(wb_valid), .wb_prd(wb_prd),
    .flush_pipeline(flush_pipeline),
    .disp_en(disp_en), .disp_rob_idx(disp_rob_idx),
    .disp_prs1_rdy(disp_prs1_rdy), .disp_prs2_rdy(disp_prs2_rdy),
    .disp_prd(disp_prd), .disp_prs1(disp_prs1), .disp_prs2(disp_prs2),
    .disp_pc(disp_pc), .disp_imm(disp_imm),
    .disp_is_load(disp_is_load), .disp_is_store(disp_is_store)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ren();
    ren_valid = '0; ren_rd_valid = '0; ren_rs1_valid = '0; ren_rs2_valid = '0;
    ren_is_load = '0; ren_is_store = '0;
    ren_prd = '0; ren_prs1 = '0; ren_prs2 = '0; ren_pc = '0; ren_imm = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    clr_ren();
    rob_free_count = 6'd10; iq_free_count = 6'd10;
    wb_valid = '0; wb_prd = '0; flush_pipeline = 1'b0;
    tick(); tick();
    #1;
    check("rst_ready", 64'(dispatch_ready), 64'd1);
    check("rst_en", 64'(disp_en), 64'd0);
    reset_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(dispatch_ready), 64'd1);
    check("post_rst_en", 64'(disp_en), 64'd0);

    // Bundle A: prd 5 / 6
    ren_valid = 2'b11; ren_rd_valid = 2'b11; ren_prd[0] = 6'd5; ren_prd[1] = 6'd6;
    ren_pc[0] = 32'h100; ren_pc[1] = 32'h104; ren_is_load = 2'b01; ren_is_store = 2'b10;
    #1;
    check("A_pre_en", 64'(disp_en), 64'd0);
    tick();
    clr_ren();
    #1;
    check("A_en", 64'(disp_en), 64'b11);
    check("A_idx0", 64'(disp_rob_idx[0]), 64'd0);
    check("A_idx1", 64'(disp_rob_idx[1]), 64'd1);
    check("A_pc1", 64'(disp_pc[1]), 64'h104);
    check("A_prd0", 64'(disp_prd[0]), 64'd5);
    check("A_load", 64'(disp_is_load), 64'b01);
    check("A_store", 64'(disp_is_store), 64'b10);
    check("A_ready", 64'(dispatch_ready), 64'd1);

    // Bundle B: sources on busy 5/6, stalls on rob_free_count=1
    ren_valid = 2'b11; ren_rs1_valid = 2'b11; ren_prs1[0] = 6'd5; ren_prs1[1] = 6'd6;
    ren_rs2_valid = 2'b11; ren_prs2[0] = 6'd0; ren_prs2[1] = 6'd3;
    tick();
    clr_ren();
    rob_free_count = 6'd1;
    #1;
    check("B_stall_en", 64'(disp_en), 64'd0);
    check("B_stall_ready", 64'(dispatch_ready), 64'd0);
    check("B_rs1_rdy", 64'(disp_prs1_rdy), 64'b00);
    check("B_rs2_rdy", 64'(disp_prs2_rdy), 64'b11);
    check("B_idx0", 64'(disp_rob_idx[0]), 64'd2);
    tick();
    #1;
    check("B_stall2_en", 64'(disp_en), 64'd0);
    check("B_stall2_ready", 64'(dispatch_ready), 64'd0);
    rob_free_count = 6'd2;
    #1;
    check("B_fire_en", 64'(disp_en), 64'b11);
    check("B_fire_idx1", 64'(disp_rob_idx[1]), 64'd3);
    check("B_fire_ready", 64'(dispatch_ready), 64'd1);
    rob_free_count = 6'd10;

    // Bundle C: lane1 depends on lane0 prd 7
    ren_valid = 2'b11; ren_rd_valid = 2'b01; ren_prd[0] = 6'd7;
    ren_rs1_valid = 2'b11; ren_prs1[0] = 6'd8; ren_prs1[1] = 6'd7;
    ren_rs2_valid = 2'b10; ren_prs2[1] = 6'd6;
    tick();
    clr_ren();
    #1;
    check("C_idx0", 64'(disp_rob_idx[0]), 64'd4);
    check("C_rs1_rdy", 64'(disp_prs1_rdy), 64'b01);
    check("C_rs2_rdy", 64'(disp_prs2_rdy), 64'b01);
    check("C_en", 64'(disp_en), 64'b11);
    tick();
    wb_valid = 2'b11; wb_prd[0] = 6'd7; wb_prd[1] = 6'd6;
    tick();
    wb_valid = '0;

    // Bundle D: 7 and 6 now free, 5 still busy
    ren_valid = 2'b11; ren_rs1_valid = 2'b11; ren_prs1[0] = 6'd7; ren_prs1[1] = 6'd5;
    ren_rs2_valid = 2'b01; ren_prs2[0] = 6'd6;
    tick();
    clr_ren();
    #1;
    check("D_rs1_rdy", 64'(disp_prs1_rdy), 64'b01);
    check("D_rs2_rdy", 64'(disp_prs2_rdy), 64'b11);
    check("D_idx0", 64'(disp_rob_idx[0]), 64'd6);

    // Bundle E: prd 9 set while writeback of 9 arrives (set wins)
    ren_valid = 2'b01; ren_rd_valid = 2'b01; ren_prd[0] = 6'd9;
    tick();
    clr_ren();
    #1;
    check("E_en", 64'(disp_en), 64'b01);
    check("E_idx0", 64'(disp_rob_idx[0]), 64'd8);
    wb_valid = 2'b01; wb_prd[0] = 6'd9;
    tick();
    wb_valid = '0;

    // Bundle F: stalled, sources on preg 9
    rob_free_count = 6'd0;
    ren_valid = 2'b11; ren_rd_valid = 2'b01; ren_prd[0] = 6'd9;
    ren_rs2_valid = 2'b11; ren_prs2[0] = 6'd9; ren_prs2[1] = 6'd9;
    tick();
    clr_ren();
    #1;
    check("F_en", 64'(disp_en), 64'd0);
    check("F_ready", 64'(dispatch_ready), 64'd0);
    check("F_set_wins", 64'(disp_prs2_rdy), 64'b00);
    wb_valid = 2'b01; wb_prd[0] = 6'd9;
    #1;
`ifdef DISPATCH_WB_BYPASS_EN
    check("F_wb_same", 64'(disp_prs2_rdy), 64'b01);
`else
    check("F_wb_same", 64'(disp_prs2_rdy), 64'b00);
`endif
    tick();
    wb_valid = '0;
    #1;
    check("F_wb_next", 64'(disp_prs2_rdy), 64'b01);
    check("F_idx0", 64'(disp_rob_idx[0]), 64'd9);

    // Flush while F stalls, with room available and a new bundle offered
    flush_pipeline = 1'b1; rob_free_count = 6'd10; ren_valid = 2'b11;
    #1;
    check("flush_en", 64'(disp_en), 64'd0);
    check("flush_ready", 64'(dispatch_ready), 64'd0);
    tick();
    flush_pipeline = 1'b0;
    clr_ren();
    #1;
    check("post_flush_ready", 64'(dispatch_ready), 64'd1);
    check("post_flush_en", 64'(disp_en), 64'd0);

    // Bundle G: preg 5 cleared and tail reset by flush
    ren_valid = 2'b11; ren_rs1_valid = 2'b01; ren_prs1[0] = 6'd5;
    tick();
    clr_ren();
    #1;
    check("G_idx0", 64'(disp_rob_idx[0]), 64'd0);
    check("G_idx1", 64'(disp_rob_idx[1]), 64'd1);
    check("G_rs1_rdy", 64'(disp_prs1_rdy), 64'b11);
    check("G_en", 64'(disp_en), 64'b11);

    // Back-to-back 2-lane bundles walk the tail up to 28
    ren_valid = 2'b11;
    for (int n = 0; n < 14; n++) begin
      tick();
      #1;
      check("walk_idx0", 64'(disp_rob_idx[0]), 64'(2 + 2 * n));
    end
    ren_valid = 2'b01;
    tick();
    #1;
    check("wrap_idx30", 64'(disp_rob_idx[0]), 64'd30);
    tick();
    #1;
    check("wrap_idx31", 64'(disp_rob_idx[0]), 64'd31);
    check("wrap_en01", 64'(disp_en), 64'b01);
    ren_valid = 2'b11;
    tick();
    #1;
    check("wrap_idx0", 64'(disp_rob_idx[0]), 64'd0);
    check("wrap_idx1", 64'(disp_rob_idx[1]), 64'd1);
    ren_valid = 2'b01;
    tick();
    #1;
    check("wrap_tail2", 64'(disp_rob_idx[0]), 64'd2);
    ren_valid = 2'b10;
    tick();
    #1;
    check("lane1_only_en", 64'(disp_en), 64'b10);
    check("lane1_only_idx", 64'(disp_rob_idx[1]), 64'd3);
    clr_ren();
    tick();

    // Reset during a stall drops the held bundle
    rob_free_count = 6'd0; ren_valid = 2'b11;
    tick();
    clr_ren();
    #1;
    check("mid_stall_en", 64'(disp_en), 64'd0);
    check("mid_stall_ready", 64'(dispatch_ready), 64'd0);
    reset_n = 1'b0;
    #1;
    check("rst_stall_ready", 64'(dispatch_ready), 64'd1);
    check("rst_stall_en", 64'(disp_en), 64'd0);
    rob_free_count = 6'd10;
    tick();
    reset_n = 1'b1;
    #1;
    check("rel_en", 64'(disp_en), 64'd0);
    check("rel_ready", 64'(dispatch_ready), 64'd1);
    tick();
    #1;
    check("rel_en2", 64'(disp_en), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dispatch_stage.md
DISPATCH_STAGE -- requirements
Module: dispatch_stage

Interface
REQ-001 Parameter FETCH_W, 2, lanes per bundle.
REQ-002 Parameter PHYS_REGS, 48, physical registers; preg index 6 bits.
REQ-003 Parameter ROB_DEPTH, 32, ROB entries, power of two; index width clog2(ROB_DEPTH).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 ren_valid / ren_rd_valid / ren_rs1_valid / ren_rs2_valid / ren_is_load / ren_is_store  in  FETCH_W each  renamed bundle flags.
REQ-007 ren_prd / ren_prs1 / ren_prs2  in  FETCH_W x 6  physical regs; ren_pc, ren_imm  in  FETCH_W x 32.
REQ-008 dispatch_ready  out  1  bundle accepted from rename this cycle when high.
REQ-009 rob_free_count, iq_free_count  in  6 each  free entries downstream.
REQ-010 wb_valid  in  2, wb_prd  in  2 x 6  writeback completion, clears busy bit.
REQ-011 flush_pipeline  in  1  squash all in-flight state.
REQ-012 disp_en  out  FETCH_W  per-lane write strobe to ROB and issue queue.
REQ-013 disp_rob_idx  out  FETCH_W x clog2(ROB_DEPTH); disp_prs1_rdy, disp_prs2_rdy  out  FETCH_W; disp_prd/prs1/prs2/pc/imm/is_load/is_store mirror held bundle.

Function
REQ-014 One-bundle hold register (hold_valid + fields); captures ren_* when ren_valid!=0 and dispatch_ready.
REQ-015 need = popcount(hold lanes valid); fire = hold_valid && need<=rob_free_count && need<=iq_free_count && !flush_pipeline.
REQ-016 Bundle dispatches all-or-nothing, in order; no partial lane dispatch.
REQ-017 dispatch_ready = (!hold_valid || fire) && !flush_pipeline, combinational; capture and fire same cycle allowed (1 bundle/cycle throughput).
REQ-018 disp_en[i] = fire && hold lane i valid, combinational from hold register; latency rename-to-disp_en minimum 1 cycle.
REQ-019 ROB tail pointer: lane0 gets tail; lane1 gets tail+1 if lane0 valid else tail; tail += need on fire, wraps modulo ROB_DEPTH (31+1 -> 0).
REQ-020 Busy table PHYS_REGS bits: on fire set busy[prd] for lanes with rd_valid && prd!=0; wb_valid[k] clears busy[wb_prd[k]].
REQ-021 Same preg set and cleared same cycle: set wins.
REQ-022 Preg 0 never busy; source with rs_valid=0 reports ready=1.
REQ-023 disp_prsN_rdy[i] = !busy[prsN]; lane1 source equal to lane0 prd (lane0 rd_valid, prd!=0) reports 0 (intra-bundle dependency).
REQ-024 flush_pipeline: next edge clears hold_valid, ROB tail to 0, all busy bits to 0; disp_en forced 0 during flush cycle.
REQ-025 No stall-state change when hold_valid=0 and ren_valid=0.

Reset
REQ-026 reset_n low: hold_valid=0, tail=0, busy all 0, held fields 0; dispatch_ready=1 after deassert, disp_en=0.
REQ-027 Reset mid-stall discards held bundle; no disp_en pulse on release.

Configuration
REQ-028 Macro DISPATCH_WB_BYPASS_EN defined: wb_prd matching a held source in same cycle forces that rdy bit to 1 (lane1-on-lane0 rule still applies).
REQ-029 Macro undefined: readiness from registered busy table only; same-cycle writeback visible next cycle.

Verification
REQ-030 Reset, lane0 prd=5 lane1 prd=6, free counts 10 -> cycle+1 disp_en=2'b11, rob_idx 0/1, busy[5],busy[6]=1, tail=2.
REQ-031 rob_free_count=1 with 2-lane bundle -> disp_en=0, dispatch_ready=0 held; count raised to 2 -> both lanes fire same cycle.
REQ-032 Tail=31, bundle with lane0 valid only then 2-lane bundle -> idx 31, then 0/1, tail=2.
REQ-033 Lane0 prd=7, lane1 prs1=7 -> disp_prs1_rdy[1]=0; wb_prd=7 next cycle -> busy[7]=0.
REQ-034 Busy[9]=1, held source prs2=9, wb_prd=9 same cycle -> rdy=1 with DISPATCH_WB_BYPASS_EN, 0 without.
REQ-035 Stalled bundle plus flush_pipeline -> no disp_en, next cycle hold_valid=0, tail=0, busy all 0, dispatch_ready=1.
